// File: rtl/lsu_ssram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ssram_pkg
// Purpose  : Shared state encoding, access-size codes and lane helpers for
//            the LSU-to-SSRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_ssram_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Byte lanes touched by an access of this size starting at lane 0.
    function automatic logic [3:0] size_lane_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_lane_mask = 4'b0001;
            SIZE_H:  size_lane_mask = 4'b0011;
            SIZE_W:  size_lane_mask = 4'b1111;
            default: size_lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] offset, input logic [1:0] size);
        logic [2:0] n_bytes;
        case (size)
            SIZE_B:  n_bytes = 3'd1;
            SIZE_H:  n_bytes = 3'd2;
            SIZE_W:  n_bytes = 3'd4;
            default: n_bytes = 3'd0;
        endcase
        is_split = ({1'b0, offset} + n_bytes) > 3'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Extracts a byte/half/word from a two-word window and extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_ssram_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_window;

    assign w_window = 32'({i_hi, i_lo} >> {i_offset, 3'b000});

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_B:  o_data = i_unsigned ? {24'd0, w_window[7:0]}
                                         : {{24{w_window[7]}}, w_window[7:0]};
            SIZE_H:  o_data = i_unsigned ? {16'd0, w_window[15:0]}
                                         : {{16{w_window[15]}}, w_window[15:0]};
            SIZE_W:  o_data = w_window;
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ssram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ssram_ctrl
// Purpose  : Core load/store unit front-end for a 32-bit single-port SSRAM,
//            splitting misaligned accesses into two word cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ssram_ctrl
    import lsu_ssram_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_byte_enable,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [29:0] c_last_word = 30'((64'd1 << ADDR_BITS) - 64'd1);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;

    logic        r_write;
    logic [1:0]  r_size;
    logic [1:0]  r_offset;
    logic        r_unsigned;
    logic        r_split;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_req_split;
    logic        w_req_err;
    logic [31:0] w_wdata_masked;
    logic [7:0]  w_lanes;
    logic [63:0] w_store_data;
    logic [31:0] w_load_hi;
    logic [31:0] w_load_lo;
    logic [31:0] w_load_data;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_req_split = is_split(req_addr[1:0], req_size);
    // A split at the last word would wrap past the end of the SSRAM.
    assign w_req_err   = (req_size == 2'b11)
                      || ((req_addr >> (ADDR_BITS + 2)) != 32'd0)
                      || (w_req_split && (req_addr[31:2] == c_last_word));

    always_comb begin
        case (req_size)
            SIZE_B:  w_wdata_masked = {24'd0, req_wdata[7:0]};
            SIZE_H:  w_wdata_masked = {16'd0, req_wdata[15:0]};
            default: w_wdata_masked = req_wdata;
        endcase
    end

    assign w_lanes      = {4'b0000, size_lane_mask(r_size)} << r_offset;
    assign w_store_data = {32'd0, r_wdata} << {r_offset, 3'b000};

    assign w_load_hi = r_split ? mem_read_data : 32'd0;
    assign w_load_lo = r_split ? r_lo : mem_read_data;

    lsu_load_align u_load_align (
        .i_hi       (w_load_hi),
        .i_lo       (w_load_lo),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory strobes are decoded from registered state only.
    always_comb begin
        w_next_state          = r_state;
        mem_address           = '0;
        mem_write_data        = '0;
        mem_write_byte_enable = '0;
        mem_write_enable      = 1'b0;
        mem_read_enable       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = w_req_err ? RESP : ISSUE0;
                end
            end
            ISSUE0: begin
                mem_address = {2'b00, r_word};
                if (r_write) begin
                    mem_write_enable      = 1'b1;
                    mem_write_byte_enable = w_lanes[3:0];
                    mem_write_data        = w_store_data[31:0];
                end else begin
                    mem_read_enable = 1'b1;
                end
                if (r_split) begin
                    w_next_state = ISSUE1;
                end else begin
                    w_next_state = r_write ? RESP : RDWAIT;
                end
            end
            ISSUE1: begin
                mem_address = {2'b00, r_word + 30'd1};
                if (r_write) begin
                    mem_write_enable      = 1'b1;
                    mem_write_byte_enable = w_lanes[7:4];
                    mem_write_data        = w_store_data[63:32];
                end else begin
                    mem_read_enable = 1'b1;
                end
                w_next_state = r_write ? RESP : RDWAIT;
            end
            RDWAIT:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_size       <= '0;
            r_offset     <= '0;
            r_unsigned   <= 1'b0;
            r_split      <= 1'b0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_lo         <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_offset   <= req_addr[1:0];
                r_unsigned <= req_unsigned;
                r_split    <= w_req_split;
                r_word     <= req_addr[31:2];
                r_wdata    <= w_wdata_masked;
                if (w_req_err) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end
            end
            // First word of a split load arrives while the second is issued.
            if ((r_state == ISSUE1) && !r_write) begin
                r_lo <= mem_read_data;
            end
            if ((r_state != IDLE) && (w_next_state == RESP)) begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= (r_state == RDWAIT) ? w_load_data : 32'd0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ssram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ssram_ctrl
// Purpose  : Directed self-checking bench for lsu_ssram_ctrl with an SSRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ssram_ctrl;
    import lsu_ssram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_byte_enable;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data;

    int vectors = 0;
    int miscompares = 0;
    int resp_seen = 0;
    int resp_before;

    logic [31:0] mem_model [0:1023];
    logic [31:0] mem_rd;

    lsu_ssram_ctrl #(.ADDR_BITS(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_write             (req_write),
        .req_size              (req_size),
        .req_unsigned          (req_unsigned),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .resp_valid            (resp_valid),
        .resp_rdata            (resp_rdata),
        .resp_err              (resp_err),
        .mem_address           (mem_address),
        .mem_write_data        (mem_write_data),
        .mem_write_byte_enable (mem_write_byte_enable),
        .mem_write_enable      (mem_write_enable),
        .mem_read_enable       (mem_read_enable),
        .mem_read_data         (mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous SSRAM: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_byte_enable[b]) begin
                    mem_model[mem_address[9:0]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
                end
            end
        end
        mem_rd <= mem_read_enable ? mem_model[mem_address[9:0]] : 32'hA5A5_A5A5;
    end
    assign mem_read_data = mem_rd;

    always @(negedge clk) begin
        if (resp_valid) resp_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_mem(input string tag);
        check({tag, "_addr"}, mem_address, 32'd0);
        check({tag, "_wdata"}, mem_write_data, 32'd0);
        check({tag, "_strobes"}, 32'({mem_write_enable, mem_read_enable, mem_write_byte_enable}), 32'd0);
    endtask

    // Presents a request in cycle c; returns just after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        check("ready_at_accept", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp, input int lat);
        issue(1'b0, sz, uns, addr, 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_quiet"}, 32'(resp_valid), 32'd0);
            if (i == 1) check({tag, "_rd_strobe"}, 32'({mem_read_enable, mem_write_enable}), 32'b10);
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd0);
        check({tag, "_rdata"}, resp_rdata, exp);
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd, input int lat);
        issue(1'b1, sz, 1'b0, addr, wd);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_quiet"}, 32'(resp_valid), 32'd0);
            if (i == 1) check({tag, "_we"}, 32'(mem_write_enable), 32'd1);
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
    endtask

    task automatic do_err(input string tag, input logic [1:0] sz, input logic [31:0] addr);
        issue(1'b0, sz, 1'b0, addr, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd1);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check_idle_mem({tag, "_c1"});
        @(negedge clk);
        check({tag, "_single"}, 32'(resp_valid), 32'd0);
        check_idle_mem({tag, "_c2"});
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SIZE_W;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check_idle_mem("rst_mem");
        @(posedge clk);
        #1 rst = 1'b0;

        // Aligned word store with per-cycle strobe checks.
        issue(1'b1, SIZE_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_addr", mem_address, 32'h40);
        check("sw_be", 32'(mem_write_byte_enable), 32'hF);
        check("sw_we_re", 32'({mem_write_enable, mem_read_enable}), 32'b10);
        check("sw_data", mem_write_data, 32'hDEAD_BEEF);
        check("sw_busy", 32'(req_ready), 32'd0);
        check("sw_quiet", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("sw_resp", 32'(resp_valid), 32'd1);
        check("sw_err", 32'(resp_err), 32'd0);
        check("sw_rdata", resp_rdata, 32'd0);
        check_idle_mem("sw_resp_mem");
        @(negedge clk);
        check("sw_one_pulse", 32'(resp_valid), 32'd0);

        do_load("lw100", SIZE_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 3);
        @(negedge clk);
        check("lw100_held", resp_rdata, 32'hDEAD_BEEF);

        do_load("lb101", SIZE_B, 1'b0, 32'h0000_0101, 32'hFFFF_FFBE, 3);
        do_load("lbu101", SIZE_B, 1'b1, 32'h0000_0101, 32'h0000_00BE, 3);

        do_store("sw104", SIZE_W, 32'h0000_0104, 32'h0000_0000, 2);

        // Split half-word store across words 0x40/0x41.
        issue(1'b1, SIZE_H, 1'b0, 32'h0000_0103, 32'hFFFF_1234);
        @(negedge clk);
        check("sh_c1_addr", mem_address, 32'h40);
        check("sh_c1_be", 32'(mem_write_byte_enable), 32'b1000);
        check("sh_c1_b3", 32'(mem_write_data[31:24]), 32'h34);
        @(negedge clk);
        check("sh_c2_addr", mem_address, 32'h41);
        check("sh_c2_be", 32'(mem_write_byte_enable), 32'b0001);
        check("sh_c2_b0", 32'(mem_write_data[7:0]), 32'h12);
        check("sh_c2_quiet", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("sh_resp", 32'(resp_valid), 32'd1);
        check("sh_err", 32'(resp_err), 32'd0);

        // Word 0x40 is now 0x34ADBEEF, word 0x41 is 0x00000012.
        do_load("lhu103", SIZE_H, 1'b1, 32'h0000_0103, 32'h0000_1234, 4);
        do_load("lh101", SIZE_H, 1'b0, 32'h0000_0101, 32'hFFFF_ADBE, 3);
        do_load("lw102", SIZE_W, 1'b0, 32'h0000_0102, 32'h0012_34AD, 4);
        do_load("lw100b", SIZE_W, 1'b0, 32'h0000_0100, 32'h34AD_BEEF, 3);

        // Range and size checks, plus the legal last word.
        do_err("err_high", SIZE_W, 32'h0004_0000);
        do_err("err_wrap", SIZE_W, 32'h0003_FFFE);
        do_err("err_size", 2'b11, 32'h0000_0100);
        do_store("sw_last", SIZE_W, 32'h0003_FFFC, 32'hCAFE_F00D, 2);
        do_load("lw_last", SIZE_W, 1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, 3);

        // Busy: a store presented during a split load must be ignored.
        do_store("sw200", SIZE_W, 32'h0000_0200, 32'h1111_1111, 2);
        issue(1'b0, SIZE_W, 1'b0, 32'h0000_0102, 32'd0);
        resp_before = resp_seen;
        @(negedge clk);
        check("busy_c1_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = SIZE_W;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'h2222_2222;
        @(negedge clk);
        check("busy_c2_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("busy_c3_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("busy_resp", 32'(resp_valid), 32'd1);
        check("busy_rdata", resp_rdata, 32'h0012_34AD);
        repeat (4) @(negedge clk);
        check("busy_resp_count", 32'(resp_seen - resp_before), 32'd1);
        do_load("busy_no_store", SIZE_W, 1'b0, 32'h0000_0200, 32'h1111_1111, 3);

        // Reset while the second word of a split load is being issued.
        issue(1'b0, SIZE_W, 1'b0, 32'h0000_0102, 32'd0);
        resp_before = resp_seen;
        @(negedge clk);
        check("rmid_c1_addr", mem_address, 32'h40);
        @(negedge clk);
        check("rmid_c2_addr", mem_address, 32'h41);
        check("rmid_c2_re", 32'(mem_read_enable), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rmid_ready", 32'(req_ready), 32'd1);
        check("rmid_no_resp", 32'(resp_valid), 32'd0);
        check("rmid_rdata", resp_rdata, 32'd0);
        check_idle_mem("rmid_mem");
        do_load("rmid_new", SIZE_W, 1'b0, 32'h0000_0100, 32'h34AD_BEEF, 3);
        repeat (2) @(negedge clk);
        check("rmid_resp_count", 32'(resp_seen - resp_before), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ssram_ctrl.md
LSU_SSRAM_CTRL -- requirements
Module: lsu_ssram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 16, meaning log2 of the SSRAM depth in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1, the clock; all logic SHALL be on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a core load/store request is present.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have port req_write, input, 1, with 1 meaning store and 0 meaning load.
REQ-007 The block SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1, meaning the load zero-extends instead of sign-extending.
REQ-009 The block SHALL have port req_addr, input, 32, the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32, the extended load data; it SHALL be 0 for stores and errors.
REQ-013 The block SHALL have port resp_err, output, 1, meaning an illegal size or out-of-range access; qualified by resp_valid.
REQ-014 The block SHALL have memory ports mem_address (output, 32, word index), mem_write_data (output, 32), mem_write_byte_enable (output, 4), mem_write_enable (output, 1), mem_read_enable (output, 1) and mem_read_data (input, 32).
REQ-015 mem_read_data SHALL be valid the cycle after mem_read_enable is asserted.

Function
REQ-016 Handshake: a request SHALL be accepted on the clk edge where req_valid and req_ready are both 1.
- req_ready SHALL be 1 only in IDLE.
- Requests while busy SHALL be ignored.
REQ-017 The FSM SHALL have the states IDLE, ISSUE0, ISSUE1, RDWAIT and RESP.
REQ-018 Transitions from IDLE SHALL be as follows.
- Accept of a legal, in-range request: go to ISSUE0.
- Accept of an illegal or out-of-range request: go to RESP with err=1.
REQ-019 Transitions from ISSUE0 SHALL be as follows.
- Split access: go to ISSUE1.
- Otherwise: load goes to RDWAIT, store goes to RESP.
REQ-020 Transitions from ISSUE1 SHALL be: load to RDWAIT, store to RESP.
- RDWAIT SHALL go to RESP.
- RESP SHALL go to IDLE.
REQ-021 Offset and split rules: o = req_addr[1:0] and n = 1, 2 or 4 bytes; the access SHALL be split when o+n > 4.
REQ-022 Word addresses: ISSUE0 SHALL use W0 = req_addr[31:2]; ISSUE1 SHALL use W0+1; mem_address SHALL be zero-extended to 32 bits.
REQ-023 Store data and lanes SHALL be formed from the 64-bit value {0, wdata} << 8o.
- ISSUE0 drives the low 32 bits, with byte enables for lanes o..min(3, o+n-1).
- ISSUE1 drives the high 32 bits, with byte enables for lanes 0..o+n-5.
REQ-024 For a load, ISSUE0 and ISSUE1 SHALL assert mem_read_enable with mem_write_byte_enable = 0.
- ISSUE1 SHALL latch the low word from mem_read_data.
- RDWAIT SHALL latch the final (or only) word.
REQ-025 Load data SHALL be {hi, lo} >> 8o, truncated to n bytes, then sign- or zero-extended per req_unsigned; a word load SHALL ignore req_unsigned.
REQ-026 Range check: resp_err=1 with no memory strobe SHALL result if either of the following holds.
- req_addr[31:ADDR_BITS+2] != 0.
- The access is split and W0 = 2^ADDR_BITS-1.
REQ-027 mem_* outputs SHALL depend only on registered state, with no combinational path from req_*; outside ISSUE0/ISSUE1 all mem_* outputs SHALL be 0.
REQ-028 Latency, with accept in cycle c:
- Aligned store: resp in c+2.
- Split store: resp in c+3.
- Aligned load: resp in c+3.
- Split load: resp in c+4.
- Error: resp in c+1.
REQ-029 resp_valid SHALL be high for exactly one cycle per accepted request; resp_rdata and resp_err SHALL be held until the next resp.

Reset
REQ-030 rst SHALL force IDLE with the following outputs:
- req_ready=1;
- resp_valid=0, resp_rdata=0, resp_err=0;
- all mem_* outputs = 0.
REQ-031 rst in the middle of an operation SHALL abort it: no further strobes and no resp, and the block SHALL accept a new request in the first cycle after rst deasserts.

Structure
REQ-032 Package lsu_ssram_pkg SHALL hold the state enum and the size constants SIZE_B=2'b00, SIZE_H=2'b01 and SIZE_W=2'b10.
REQ-033 Load extraction and extension SHALL be a combinational sub-module lsu_load_align with inputs {hi, lo}, o, size and unsigned, and output 32-bit data.

Verification
REQ-034 A bench SHALL check an aligned store then load:
- Store 0xDEADBEEF to 0x100: c+1 shows mem_address=0x40, be=1111, we=1; resp in c+2 with err=0.
- Load-word 0x100: resp_rdata=0xDEADBEEF in c+3.
REQ-035 A bench SHALL check byte extension with word 0x40 = 0xDEADBEEF: lb 0x101 returns 0xFFFFFFBE and lbu 0x101 returns 0x000000BE.
REQ-036 A bench SHALL check a split half-word:
- sh 0x1234 at 0x103: c+1 addr 0x40, be=1000, data[31:24]=0x34; c+2 addr 0x41, be=0001, data[7:0]=0x12; resp c+3.
- lhu 0x103: returns 0x00001234 in c+4.
REQ-037 A bench SHALL check the range and size checks: lw 0x00040000, lw 0x0003FFFE and req_size=11 SHALL each give resp_err=1 in c+1, with resp_rdata=0 and no mem strobe.
REQ-038 A bench SHALL check busy behaviour: a second req_valid during a split load SHALL see req_ready=0 and be ignored, with exactly one resp.
REQ-039 A bench SHALL check reset mid-operation: rst during ISSUE1 of a split load SHALL give no resp and mem_* = 0, and req_ready=1 in the first cycle after rst drops.
